// File: rtl/multi_counter_pkg.sv
// Shared definitions for the multi-channel settable counter.
// Mode and direction encodings are kept here so the channel logic and any
// user-project software model agree on a single set of values.
package multi_counter_pkg;

    // Per-channel counting mode.
    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_RELOAD  = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_e;

    // Per-channel direction.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Modes whose arithmetic clamps at the bound (saturate and one-shot).
    function automatic logic mode_clamps(input mode_e m);
        return (m == MODE_SAT) || (m == MODE_ONESHOT);
    endfunction

endpackage

// File: rtl/multi_counter_if.sv
// Flattened control/status bus of the multi-channel counter.
// Channel c owns slice [c*W +: W] of every vector; the master drives the
// control fields and the counter (slave) returns the status fields.
interface multi_counter_if #(
    parameter int NUM_CH     = 4,
    parameter int WIDTH      = 32,
    parameter int STEP_WIDTH = 8
);
    logic [NUM_CH-1:0]            en_i;
    logic [NUM_CH-1:0]            dir_i;
    logic [2*NUM_CH-1:0]          mode_i;
    logic [NUM_CH*STEP_WIDTH-1:0] step_i;
    logic [NUM_CH-1:0]            set_i;
    logic [NUM_CH*WIDTH-1:0]      set_value_i;
    logic [NUM_CH*WIDTH-1:0]      limit_i;
    logic [NUM_CH-1:0]            clr_tc_i;
    logic [NUM_CH*WIDTH-1:0]      count_o;
    logic [NUM_CH-1:0]            tc_pulse_o;
    logic [NUM_CH-1:0]            tc_flag_o;
    logic [NUM_CH-1:0]            running_o;

    modport master (
        output en_i, dir_i, mode_i, step_i, set_i, set_value_i, limit_i, clr_tc_i,
        input  count_o, tc_pulse_o, tc_flag_o, running_o
    );

    modport slave (
        input  en_i, dir_i, mode_i, step_i, set_i, set_value_i, limit_i, clr_tc_i,
        output count_o, tc_pulse_o, tc_flag_o, running_o
    );
endinterface

// File: rtl/multi_counter_channel.sv
// One independent counter channel: count, reload value, one-shot running
// state, terminal-count pulse and sticky flag. All outputs are registered.
module multi_counter_channel #(
    parameter int WIDTH      = 32,
    parameter int STEP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  dir,
    input  logic [1:0]            mode,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic                  set,
    input  logic [WIDTH-1:0]      set_value,
    input  logic [WIDTH-1:0]      limit,
    input  logic                  clr_tc,
    output logic [WIDTH-1:0]      count,
    output logic                  tc_pulse,
    output logic                  tc_flag,
    output logic                  running
);
    import multi_counter_pkg::*;

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] reload_reg;
    logic             tc_pulse_reg;
    logic             tc_flag_reg;
    logic             running_reg;

    logic [WIDTH-1:0] count_next;
    logic             tc_next;
    logic             running_next;

    mode_e            mode_cur;
    logic             active;
    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   limit_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] stepped;
    logic             tc_hit;

    // One extra bit holds the carry (up) or borrow (down) of the step.
    assign mode_cur  = mode_e'(mode);
    assign step_ext  = {{(WIDTH + 1 - STEP_WIDTH){1'b0}}, step};
    assign limit_ext = {1'b0, limit};
    assign sum       = {1'b0, count_reg} + step_ext;
    assign diff      = {1'b0, count_reg} - step_ext;

    // A finished one-shot ignores enable until it is re-armed by a load.
    assign active = en && (running_reg || (mode_cur != MODE_ONESHOT));

    // Candidate next count and terminal-count condition for an enabled step.
    always_comb begin
        stepped = count_reg;
        tc_hit  = 1'b0;
        // A zero step never moves the count and never terminates.
        if (step != '0) begin
            if (mode_cur == MODE_WRAP) begin
                if (dir == DIR_DOWN) begin
                    stepped = diff[WIDTH-1:0];
                    tc_hit  = diff[WIDTH];
                end else begin
                    stepped = sum[WIDTH-1:0];
                    tc_hit  = sum[WIDTH];
                end
            end else if (mode_cur == MODE_RELOAD) begin
                if (dir == DIR_DOWN) begin
                    if (diff[WIDTH]) begin
                        stepped = reload_reg;
                        tc_hit  = 1'b1;
                    end else begin
                        stepped = diff[WIDTH-1:0];
                    end
                end else begin
                    if (sum > limit_ext) begin
                        stepped = reload_reg;
                        tc_hit  = 1'b1;
                    end else begin
                        stepped = sum[WIDTH-1:0];
                    end
                end
            end else if (mode_clamps(mode_cur)) begin
                // Pulse only on arrival at the bound, not while parked there.
                if (dir == DIR_DOWN) begin
                    stepped = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
                    tc_hit  = (stepped == '0) && (count_reg != '0);
                end else begin
                    stepped = (sum > limit_ext) ? limit : sum[WIDTH-1:0];
                    tc_hit  = (stepped == limit) && (count_reg != limit);
                end
            end
        end
    end

    // Next-state selection for count, pulse and running.
    always_comb begin
        count_next   = active ? stepped : count_reg;
        tc_next      = active && tc_hit;
        running_next = running_reg;
        if (mode_cur != MODE_ONESHOT) begin
            running_next = 1'b1;
        end else if (tc_next) begin
            running_next = 1'b0;
        end
    end

    // Channel state: reset beats load, load beats counting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg    <= '0;
            reload_reg   <= '0;
            tc_pulse_reg <= 1'b0;
            tc_flag_reg  <= 1'b0;
            running_reg  <= 1'b1;
        end else if (set) begin
            count_reg    <= set_value;
            reload_reg   <= set_value;
            tc_pulse_reg <= 1'b0;
            tc_flag_reg  <= tc_flag_reg & ~clr_tc;
            running_reg  <= 1'b1;
        end else begin
            count_reg    <= count_next;
            tc_pulse_reg <= tc_next;
            // A new terminal count wins over a simultaneous clear.
            tc_flag_reg  <= tc_next | (tc_flag_reg & ~clr_tc);
            running_reg  <= running_next;
        end
    end

    assign count    = count_reg;
    assign tc_pulse = tc_pulse_reg;
    assign tc_flag  = tc_flag_reg;
    assign running  = running_reg;

endmodule

// File: rtl/multi_counter.sv
// Multi-channel settable timer/event counter. Slices the flattened bus
// into NUM_CH independent channel instances.
module multi_counter #(
    parameter int NUM_CH     = 4,
    parameter int WIDTH      = 32,
    parameter int STEP_WIDTH = 8
) (
    input logic            clk,
    input logic            rst,
    multi_counter_if.slave bus
);
    import multi_counter_pkg::*;

    logic [WIDTH-1:0] count_ch    [NUM_CH];
    logic [NUM_CH-1:0] tc_pulse_ch;
    logic [NUM_CH-1:0] tc_flag_ch;
    logic [NUM_CH-1:0] running_ch;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            multi_counter_channel #(
                .WIDTH      (WIDTH),
                .STEP_WIDTH (STEP_WIDTH)
            ) u_channel (
                .clk       (clk),
                .rst       (rst),
                .en        (bus.en_i[gi]),
                .dir       (bus.dir_i[gi]),
                .mode      (bus.mode_i[gi*2 +: 2]),
                .step      (bus.step_i[gi*STEP_WIDTH +: STEP_WIDTH]),
                .set       (bus.set_i[gi]),
                .set_value (bus.set_value_i[gi*WIDTH +: WIDTH]),
                .limit     (bus.limit_i[gi*WIDTH +: WIDTH]),
                .clr_tc    (bus.clr_tc_i[gi]),
                .count     (count_ch[gi]),
                .tc_pulse  (tc_pulse_ch[gi]),
                .tc_flag   (tc_flag_ch[gi]),
                .running   (running_ch[gi])
            );

            assign bus.count_o[gi*WIDTH +: WIDTH] = count_ch[gi];
        end
    endgenerate

    assign bus.tc_pulse_o = tc_pulse_ch;
    assign bus.tc_flag_o  = tc_flag_ch;
    assign bus.running_o  = running_ch;

endmodule
